// File: rtl/alu_sched.sv
// Round-robin scheduler for two requesters sharing one serial-operand ALU_2.
// Drives the ALU clear/load/run/readback sequence and returns the result with a one-cycle ack.
module alu_sched #(
    parameter int unsigned LAT_AS = 6,
    parameter int unsigned LAT_MD = 72
) (
    input  logic        CLk,
    input  logic        RST,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [1:0]  op_a,
    input  logic [1:0]  op_b,
    input  logic [15:0] opa_a,
    input  logic [15:0] opa_b,
    input  logic [7:0]  opb_a,
    input  logic [7:0]  opb_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic [15:0] result,
    output logic        busy,
    output logic        alu_begin,
    output logic        alu_rst,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus
);

    typedef enum logic [3:0] {IDLE, CLR, LD1, LD2, LDB, RUN, RD0, RD1, DONE} state_t;

    localparam logic [1:0] OP_DIV = 2'd3;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [15:0] opa_q;
    logic [7:0]  opb_q;
    logic        gnt_b_q;
    logic        last_b_q;
    logic [7:0]  cnt_q;
    logic [15:0] result_q;
    logic        ack_a_q, ack_b_q, begin_q, arst_q;
    logic [7:0]  inbus_q;

    // B wins only if A is idle or A was the last one served.
    logic pick_b;
    assign pick_b = req_b & (~req_a | ~last_b_q);

    always_ff @(posedge CLk or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            gnt_b_q  <= 1'b0;
            last_b_q <= 1'b1;
            cnt_q    <= '0;
            result_q <= '0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            begin_q  <= 1'b0;
            arst_q   <= 1'b0;
            inbus_q  <= '0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            arst_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_a || req_b) begin
                        gnt_b_q <= pick_b;
                        op_q    <= pick_b ? op_b  : op_a;
                        opa_q   <= pick_b ? opa_b : opa_a;
                        opb_q   <= pick_b ? opb_b : opb_a;
                        begin_q <= 1'b1;
                        arst_q  <= 1'b1;
                        state_q <= CLR;
                    end
                end
                CLR: begin
                    inbus_q <= (op_q == OP_DIV) ? opa_q[15:8] : opa_q[7:0];
                    state_q <= LD1;
                end
                LD1: begin
                    if (op_q == OP_DIV) begin
                        inbus_q <= opa_q[7:0];
                        state_q <= LD2;
                    end else begin
                        inbus_q <= opb_q;
                        state_q <= LDB;
                    end
                end
                LD2: begin
                    inbus_q <= opb_q;
                    state_q <= LDB;
                end
                LDB: begin
                    cnt_q   <= op_q[1] ? 8'(LAT_MD) : 8'(LAT_AS);
                    state_q <= RUN;
                end
                RUN: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_q <= RD0;
                end
                RD0: begin
                    result_q[7:0] <= alu_outbus;
                    if (op_q[1]) begin
                        state_q <= RD1;
                    end else begin
                        result_q[15:8] <= 8'h00;
                        ack_a_q <= ~gnt_b_q;
                        ack_b_q <= gnt_b_q;
                        begin_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                RD1: begin
                    result_q[15:8] <= alu_outbus;
                    ack_a_q <= ~gnt_b_q;
                    ack_b_q <= gnt_b_q;
                    begin_q <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    last_b_q <= gnt_b_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // op stays latched for the whole transaction so the ALU sees a stable opcode.
    assign alu_op    = op_q;
    assign alu_begin = begin_q;
    assign alu_rst   = arst_q;
    assign alu_inbus = inbus_q;
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign result    = result_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: a behavioural ALU_2 stand-in plus directed and random transactions.
module tb_alu_sched;
    localparam int LAS = 6;
    localparam int LMD = 72;

    logic        CLk = 1'b0;
    logic        RST = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [1:0]  op_a = '0, op_b = '0;
    logic [15:0] opa_a = '0, opa_b = '0;
    logic [7:0]  opb_a = '0, opb_b = '0;
    logic        ack_a, ack_b, busy, alu_begin, alu_rst;
    logic [15:0] result;
    logic [1:0]  alu_op;
    logic [7:0]  alu_inbus, alu_outbus;

    int nvec = 0;
    int nerr = 0;

    alu_sched #(.LAT_AS(LAS), .LAT_MD(LMD)) dut (
        .CLk(CLk), .RST(RST),
        .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
        .opa_a(opa_a), .opa_b(opa_b), .opb_a(opb_a), .opb_b(opb_b),
        .ack_a(ack_a), .ack_b(ack_b), .result(result), .busy(busy),
        .alu_begin(alu_begin), .alu_rst(alu_rst), .alu_op(alu_op),
        .alu_inbus(alu_inbus), .alu_outbus(alu_outbus)
    );

    always #5 CLk = ~CLk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] calc(input logic [1:0] op, input logic [15:0] a, input logic [7:0] b);
        case (op)
            2'd0:    calc = {8'h00, 8'(a[7:0] + b)};
            2'd1:    calc = {8'h00, 8'(a[7:0] - b)};
            2'd2:    calc = 16'(a[7:0]) * 16'(b);
            default: calc = (b == 8'd0) ? 16'hFFFF : {8'(a % 16'(b)), 8'(a / 16'(b))};
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        if (op < 2'd2) return LAS + 5;
        if (op == 2'd2) return LMD + 6;
        return LMD + 7;
    endfunction

    // ALU_2 stand-in: clears on RST, shifts in operand bytes while Begin is high,
    // presents the low result byte LAT cycles after the last byte, high byte the cycle after.
    int         k = 0;
    logic [7:0] bytes [3] = '{8'h00, 8'h00, 8'h00};
    logic [1:0] mop = 2'd0;
    int         nload, mlat;
    logic [15:0] mres;

    always @(posedge CLk) begin
        if (alu_rst) begin
            k   <= 0;
            mop <= alu_op;
        end else if (alu_begin) begin
            if (k < nload) bytes[k] <= alu_inbus;
            k <= k + 1;
        end
    end

    always_comb begin
        nload = (mop == 2'd3) ? 3 : 2;
        mlat  = mop[1] ? LMD : LAS;
        mres  = (mop == 2'd3) ? calc(mop, {bytes[0], bytes[1]}, bytes[2])
                              : calc(mop, {8'h00, bytes[0]}, bytes[1]);
        alu_outbus = 8'hEE;
        if (k == nload + mlat)     alu_outbus = mres[7:0];
        if (k == nload + mlat + 1) alu_outbus = mres[15:8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack_a"}, 32'(ack_a), 0);
        chk({tag, "_ack_b"}, 32'(ack_b), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_begin"}, 32'(alu_begin), 0);
        chk({tag, "_alurst"}, 32'(alu_rst), 0);
    endtask

    // One transaction from one side; entered and left on a negedge.
    task automatic do_txn(input bit side, input logic [1:0] op, input logic [15:0] a,
                          input logic [7:0] b, input string tag);
        int n = 0;
        bit oth = 0, blow = 0, beg = 1;
        logic [15:0] exp = calc(op, (op == 2'd3) ? a : {8'h00, a[7:0]}, b);
        if (!side) begin op_a = op; opa_a = a; opb_a = b; req_a = 1'b1; end
        else       begin op_b = op; opa_b = a; opb_b = b; req_b = 1'b1; end
        @(posedge CLk);
        #1;
        op_a = 2'($urandom); opa_a = 16'($urandom); opb_a = 8'($urandom);
        op_b = 2'($urandom); opa_b = 16'($urandom); opb_b = 8'($urandom);
        for (int c = 1; c <= 300; c++) begin
            @(negedge CLk);
            if (side ? ack_a : ack_b) oth = 1;
            if (!busy) blow = 1;
            if (side ? ack_b : ack_a) begin n = c; beg = alu_begin; break; end
        end
        req_a = 1'b0; req_b = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'(lat_of(op)));
        chk({tag, "_result"}, 32'(result), 32'(exp));
        chk({tag, "_other_ack"}, 32'(oth), 0);
        chk({tag, "_busy_gap"}, 32'(blow), 0);
        chk({tag, "_begin_done"}, 32'(beg), 0);
        @(negedge CLk);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_hold"}, 32'(result), 32'(exp));
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [1:0]  rop;
        bit          rside;
        int          t [3];
        bit          who [3];
        logic [15:0] res [3];
        int          na, bl;

        // reset state
        repeat (3) @(negedge CLk);
        chk_idle_outputs("reset");
        chk("reset_result", 32'(result), 0);
        chk("reset_op", 32'(alu_op), 0);
        chk("reset_inbus", 32'(alu_inbus), 0);
        RST = 1'b1;
        @(negedge CLk);

        do_txn(0, 2'd0, 16'd24, 8'd31, "add_a");
        chk("add_ld1", 32'(bytes[0]), 24);
        chk("add_ldb", 32'(bytes[1]), 31);
        do_txn(1, 2'd1, 16'd99, 8'd55, "sub_b");
        do_txn(0, 2'd2, 16'd32, 8'd25, "mul_a");
        do_txn(1, 2'd3, 16'h0999, 8'd25, "div_b");
        chk("div_ld1", 32'(bytes[0]), 32'h09);
        chk("div_ld2", 32'(bytes[1]), 32'h99);
        chk("div_ldb", 32'(bytes[2]), 32'h19);

        // both requesters raised together after reset and held
        RST = 1'b0;
        @(negedge CLk);
        RST = 1'b1;
        @(negedge CLk);
        op_a = 2'd0; opa_a = 16'd10;  opb_a = 8'd20;
        op_b = 2'd2; opa_b = 16'd200; opb_b = 8'd3;
        req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 3; i++) begin t[i] = 0; who[i] = 0; res[i] = '0; end
        na = 0; bl = 0;
        @(posedge CLk);
        for (int c = 1; c <= 400 && na < 3; c++) begin
            @(negedge CLk);
            if (!busy) bl++;
            if (ack_a && ack_b) chk("both_dual_ack", 1, 0);
            if (ack_a || ack_b) begin
                t[na] = c; who[na] = ack_b; res[na] = result; na++;
                if (na == 3) begin req_a = 1'b0; req_b = 1'b0; end
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        chk("both_count", 32'(na), 3);
        chk("both_who0", 32'(who[0]), 0);
        chk("both_who1", 32'(who[1]), 1);
        chk("both_who2", 32'(who[2]), 0);
        chk("both_t0", 32'(t[0]), 32'(LAS + 5));
        chk("both_t1", 32'(t[1]), 32'(LAS + 5 + 1 + LMD + 6));
        chk("both_t2", 32'(t[2]), 32'(LAS + 5 + 1 + LMD + 6 + 1 + LAS + 5));
        chk("both_res0", 32'(res[0]), 32'h001E);
        chk("both_res1", 32'(res[1]), 32'h0258);
        chk("both_res2", 32'(res[2]), 32'h001E);
        chk("both_idle_gaps", 32'(bl), 2);
        @(negedge CLk);

        // reset in the middle of a mul run, request held across reset
        op_a = 2'd2; opa_a = 16'd32; opb_a = 8'd25; req_a = 1'b1;
        @(posedge CLk);
        repeat (20) @(negedge CLk);
        chk("pre_rst_busy", 32'(busy), 1);
        RST = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_result", 32'(result), 0);
        chk("midrst_inbus", 32'(alu_inbus), 0);
        @(negedge CLk);
        chk("midrst_ack", 32'(ack_a), 0);
        RST = 1'b1;
        do_txn(0, 2'd2, 16'd32, 8'd25, "rst_retry");

        // random single-requester traffic
        for (int i = 0; i < 16; i++) begin
            rside = 1'($urandom);
            rop   = 2'($urandom);
            ra    = 16'($urandom);
            rb    = 8'($urandom);
            if (rop == 2'd3 && rb == 8'd0) rb = 8'd1;
            do_txn(rside, rop, ra, rb, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler that shares one serial-operand `ALU_2` instance. It arbitrates round-robin between requesters A and B and runs the ALU's load protocol: ALU clear, operand bytes on `inbus`, then a fixed-latency wait. It reads back an 8- or 16-bit result and returns it with a one-cycle acknowledge. It sits between the system-side requesters and `ALU_2`, and is the only driver of the ALU's `Begin`, `RST`, `op` and `inbus`.

## Interface
- `LAT_AS`, default 6: ALU run cycles for add/sub, range 1..255
- `LAT_MD`, default 72: ALU run cycles for mul/div, range 1..255
- `CLk  in  1`: the single clock; everything is rising-edge
- `RST  in  1`: asynchronous, active-low reset
- `req_a` / `req_b  in  1`: request from A or B; held high until the matching ack
- `op_a` / `op_b  in  2`: 0 add, 1 sub, 2 mul, 3 div
- `opa_a` / `opa_b  in  16`: first operand; bits [15:8] are used only for div (dividend high byte)
- `opb_a` / `opb_b  in  8`: second operand (addend, subtrahend, multiplier or divisor)
- `ack_a` / `ack_b  out  1`: one-cycle pulse; `result` is valid in the same cycle
- `result  out  16`: add/sub gives {8'h00, byte}; mul gives the product; div gives {remainder, quotient}
- `busy  out  1`: high in every state except IDLE
- `alu_begin  out  1`, `alu_rst  out  1`, `alu_op  out  2`, `alu_inbus  out  8`: drive `ALU_2` Begin/RST/op/inbus
- `alu_outbus  in  8`: `ALU_2` outbus

## Operation
- States: IDLE, CLR, LD1, LD2, LDB, RUN, RD0, RD1, DONE.
- **IDLE**
  - If any req is high at the clock edge, grant one requester and go to CLR.
  - When both are high, grant the one not granted last. The last-granted pointer resets to B, so A wins first.
  - Latch the granted op and operands into internal registers; requester inputs are ignored until DONE.
- **CLR** (1 cycle): `alu_begin=1`, `alu_rst=1`, `alu_op`=latched op.
- **LD1** (1 cycle): `alu_inbus` = opa[15:8] for div, opa[7:0] otherwise. Next state is LD2 for div, LDB otherwise.
- **LD2** (div only, 1 cycle): `alu_inbus` = opa[7:0].
- **LDB** (1 cycle): `alu_inbus` = opb. `alu_inbus` holds opb through RUN, RD0 and RD1.
- **RUN**
  - An 8-bit down-counter is loaded with LAT_AS or LAT_MD on entry to RUN and decrements once per cycle.
  - Exit to RD0 after exactly LAT cycles.
- **RD0**: capture `alu_outbus` into result[7:0]. Next state is RD1 for mul/div; for add/sub, result[15:8] is cleared to 0 and the next state is DONE.
- **RD1**: capture `alu_outbus` into result[15:8] (product high byte for mul, remainder for div).
- **DONE** (1 cycle)
  - `alu_begin=0`; pulse the granted ack; update the last-granted pointer; return to IDLE.
  - `result` holds its value until the next RD0.
- `alu_begin` is 1 in CLR through RD1 and 0 in IDLE and DONE. `alu_rst` is 1 only in CLR.
- ALU signed/overflow semantics are the ALU's own. This block only moves bytes and never modifies them.

## Timing
- **Reset values:** every output is 0, the state is IDLE, the pointer is B.
- **Reset asserted mid-transaction:** return to IDLE immediately. No ack is issued and the in-flight request is dropped. A requester that still holds req after reset release is re-served from scratch.
- **Latency**, counted with the grant edge as cycle 0; ack is high in cycle:
  - add/sub: LAT_AS+5
  - mul: LAT_MD+6
  - div: LAT_MD+7
- **Throughput:** at least one IDLE cycle separates transactions. A req that is still high in that IDLE cycle is treated as a new request.
- **Deasserting req before ack** is a protocol violation. The transaction still completes and still acks.
- **Operand changes after grant** have no effect.
- **Both reqs held continuously:** service alternates A, B, A, B.

## Test plan
- Reset, then A: add 24+31 with LAT_AS=6 -> LD1 drives 24, LDB drives 31, `ack_a` in cycle 11, `result`=0x0037.
- B: sub 99−55 -> `ack_b` in cycle 11, `result`=0x002C, `ack_a` stays 0.
- A: mul 32×25 with LAT_MD=72 -> `ack_a` in cycle 78, `result`=0x0320, RD1 captures 0x03.
- B: div opa=0x0999, opb=25 -> LD1=0x09, LD2=0x99, LDB=0x19, `ack_b` in cycle 79, `result`={0x07, 0x62}.
- A (add) and B (mul) raised in the same cycle after reset, both held -> A is served first with ack_a. After one IDLE cycle B is granted, then A again; `busy` drops only in the IDLE gaps.
- `RST` pulled low during RUN of a mul -> all outputs are 0 that cycle, no ack, state IDLE. With req held after release, the operation restarts and completes with full latency.
